// File: rtl/led_pkg.sv
// ============================================================================
//  Module      : led_pkg
//  Description : Shared constants and types for the RGB PWM fader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    localparam logic [1:0] CH_RGB0 = 2'd0;
    localparam logic [1:0] CH_RGB1 = 2'd1;
    localparam logic [1:0] CH_RGB2 = 2'd2;
    localparam logic [1:0] CH_ALL  = 2'd3;

    localparam int PWM_BITS_DEFAULT = 8;
    localparam int PWM_MAX          = (1 << PWM_BITS_DEFAULT) - 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } chan_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ============================================================================
//  Module      : pwm_channel
//  Description : One LED channel: level/target tracking, ramp FSM, PWM compare.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                apply,
    input  logic                fade,
    input  logic [PWM_BITS-1:0] level,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] pcnt_next,
    output logic                pwm,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] c_duty_max = '1;

    chan_state_t         r_state;
    chan_state_t         w_state_next;
    logic [PWM_BITS-1:0] r_cur;
    logic [PWM_BITS-1:0] r_target;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] w_cur_next;
    logic [PWM_BITS-1:0] w_target_next;
    logic [PWM_BITS-1:0] w_duty_next;
    logic                r_pwm;
    logic                r_busy;
    logic                w_pwm_next;

    // A command apply takes priority over a ramp step in the same cycle.
    always_comb begin
        w_state_next  = r_state;
        w_cur_next    = r_cur;
        w_target_next = r_target;
        if (apply) begin
            w_target_next = level;
            if (!fade) begin
                w_cur_next   = level;
                w_state_next = IDLE;
            end else begin
                w_state_next = (level != r_cur) ? RAMP : IDLE;
            end
        end else if ((r_state == RAMP) && tick) begin
            w_cur_next = (r_target > r_cur) ? (r_cur + 1'b1) : (r_cur - 1'b1);
            if (w_cur_next == r_target) begin
                w_state_next = IDLE;
            end
        end
    end

    // Duty is latched only at the period boundary so a period is never cut short.
    always_comb begin
        w_duty_next = wrap ? r_cur : r_duty;
        w_pwm_next  = (w_duty_next == c_duty_max) || (pcnt_next < w_duty_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cur    <= '0;
            r_target <= '0;
            r_duty   <= '0;
            r_pwm    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cur    <= w_cur_next;
            r_target <= w_target_next;
            r_duty   <= w_duty_next;
            r_pwm    <= w_pwm_next;
            r_busy   <= (w_state_next == RAMP);
        end
    end

    assign pwm  = r_pwm;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/rgb_pwm_fader.sv
// ============================================================================
//  Module      : rgb_pwm_fader
//  Description : Three-channel PWM fader feeding the SB_RGBA_DRV LED driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_pwm_fader
    import led_pkg::*;
#(
    parameter int TICK_LOG2 = 16,
    parameter int PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_chan,
    input  logic [PWM_BITS-1:0] cmd_level,
    input  logic                cmd_fade,
    output logic [2:0]          pwm_out,
    output logic [2:0]          busy
);

    logic                 r_cmd_ready;
    logic                 r_apply;
    logic [1:0]           r_cmd_chan;
    logic [PWM_BITS-1:0]  r_cmd_level;
    logic                 r_cmd_fade;
    logic [TICK_LOG2-1:0] r_presc;
    logic [PWM_BITS-1:0]  r_pcnt;
    logic [PWM_BITS-1:0]  w_pcnt_next;
    logic                 w_accept;
    logic                 w_tick;
    logic                 w_wrap;

    assign w_accept    = cmd_valid & r_cmd_ready;
    assign w_tick      = &r_presc;
    assign w_wrap      = &r_pcnt;
    assign w_pcnt_next = r_pcnt + 1'b1;

    // The apply pulse re-opens the command register, giving one command per two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_ready <= 1'b1;
            r_apply     <= 1'b0;
            r_cmd_chan  <= '0;
            r_cmd_level <= '0;
            r_cmd_fade  <= 1'b0;
            r_presc     <= '0;
            r_pcnt      <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_pcnt  <= w_pcnt_next;
            r_apply <= w_accept;
            if (r_apply) begin
                r_cmd_ready <= 1'b1;
            end else if (w_accept) begin
                r_cmd_ready <= 1'b0;
            end
            if (w_accept) begin
                r_cmd_chan  <= cmd_chan;
                r_cmd_level <= cmd_level;
                r_cmd_fade  <= cmd_fade;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_ch
            logic w_apply;
            assign w_apply = r_apply & ((r_cmd_chan == CH_ALL) | (r_cmd_chan == 2'(g)));

            pwm_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .tick      (w_tick),
                .apply     (w_apply),
                .fade      (r_cmd_fade),
                .level     (r_cmd_level),
                .wrap      (w_wrap),
                .pcnt_next (w_pcnt_next),
                .pwm       (pwm_out[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rgb_pwm_fader.sv
// ============================================================================
//  Module      : tb_rgb_pwm_fader
//  Description : Self-checking bench for rgb_pwm_fader with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rgb_pwm_fader;

    localparam int TICK_LOG2 = 2;
    localparam int PWM_BITS  = 8;
    localparam int TICKS     = 1 << TICK_LOG2;
    localparam int PERIOD    = 1 << PWM_BITS;
    localparam int DMAX      = PERIOD - 1;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_chan  = 2'd0;
    logic [7:0] cmd_level = 8'd0;
    logic       cmd_fade  = 1'b0;
    logic       cmd_ready;
    logic [2:0] pwm_out;
    logic [2:0] busy;

    int checks = 0;
    int errors = 0;

    rgb_pwm_fader #(
        .TICK_LOG2 (TICK_LOG2),
        .PWM_BITS  (PWM_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_chan  (cmd_chan),
        .cmd_level (cmd_level),
        .cmd_fade  (cmd_fade),
        .pwm_out   (pwm_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: integer levels, a channel is ramping whenever cur != target.
    int m_cur[3], m_tgt[3], m_duty[3];
    int m_pcnt, m_presc, m_chan, m_lvl;
    bit m_ready, m_pend, m_fade, m_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                m_cur[c] = 0; m_tgt[c] = 0; m_duty[c] = 0;
            end
            m_pcnt = 0; m_presc = 0; m_ready = 1; m_pend = 0;
            m_chan = 0; m_lvl = 0; m_fade = 0;
        end else begin
            m_presc = (m_presc + 1) % TICKS;
            m_tick  = (m_presc == 0);
            m_pcnt  = (m_pcnt + 1) % PERIOD;
            for (int c = 0; c < 3; c++)
                if (m_pcnt == 0) m_duty[c] = m_cur[c];
            for (int c = 0; c < 3; c++) begin
                if (m_pend && (m_chan == 3 || m_chan == c)) begin
                    m_tgt[c] = m_lvl;
                    if (!m_fade) m_cur[c] = m_lvl;
                end else if (m_tick && m_cur[c] != m_tgt[c]) begin
                    m_cur[c] = m_cur[c] + ((m_tgt[c] > m_cur[c]) ? 1 : -1);
                end
            end
            if (m_pend) begin
                m_pend = 0; m_ready = 1;
            end else if (cmd_valid && m_ready) begin
                m_chan = int'(cmd_chan); m_lvl = int'(cmd_level); m_fade = cmd_fade;
                m_pend = 1; m_ready = 0;
            end
        end
    end

    function automatic logic [2:0] exp_pwm();
        logic [2:0] v;
        for (int c = 0; c < 3; c++)
            v[c] = (m_duty[c] == DMAX) || (m_pcnt < m_duty[c]);
        return v;
    endfunction

    function automatic logic [2:0] exp_busy();
        logic [2:0] v;
        for (int c = 0; c < 3; c++) v[c] = (m_cur[c] != m_tgt[c]);
        return v;
    endfunction

    // Presents one command and returns on the negedge following its acceptance edge.
    task automatic send_cmd(input int ch, input int lvl, input bit fd);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_cmd_timeout: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
        end
        cmd_chan = 2'(ch); cmd_level = 8'(lvl); cmd_fade = fd; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 3'b000) begin errors++; $display("FAIL reset_pwm: got %b required 000", pwm_out); end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b required 000", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
        rst = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (pwm_out !== 3'b000 || busy !== 3'b000 || cmd_ready !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_outputs: %0d bad cycles, required 0", bad); end
    endtask

    task automatic test_immediate();
        int hi = 0, other = 0;
        send_cmd(0, 64, 1'b0);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_drop: got %b required 0", cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_return: got %b required 1", cmd_ready); end
        repeat (260) @(negedge clk);
        repeat (PERIOD) begin
            @(negedge clk);
            if (pwm_out[0] === 1'b1) hi++;
            if (pwm_out[2:1] !== 2'b00) other++;
        end
        checks++; if (hi != 64) begin errors++; $display("FAIL duty64_high: got %0d required 64", hi); end
        checks++; if (other != 0) begin errors++; $display("FAIL duty64_others: got %0d required 0", other); end
    endtask

    task automatic test_extremes();
        int bad = 0;
        send_cmd(3, 255, 1'b0);
        repeat (260) @(negedge clk);
        repeat (2 * PERIOD) begin
            @(negedge clk);
            if (pwm_out !== 3'b111) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_on: %0d cycles not 111, required 0", bad); end
        bad = 0;
        send_cmd(3, 0, 1'b0);
        repeat (260) @(negedge clk);
        repeat (2 * PERIOD) begin
            @(negedge clk);
            if (pwm_out !== 3'b000 || busy !== 3'b000) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_off: %0d cycles not 000, required 0", bad); end
    endtask

    task automatic test_fade();
        int len = 0, hi = 0;
        send_cmd(1, 10, 1'b1);
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL fade_busy_early: got %b required 0", busy[1]); end
        @(negedge clk);
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL fade_busy_rise: got %b required 1", busy[1]); end
        while (busy[1] === 1'b1 && len < 200) begin @(negedge clk); len++; end
        checks++;
        if (len < 36 || len > 44) begin errors++; $display("FAIL fade_duration: got %0d cycles required 36..44", len); end
        repeat (260) @(negedge clk);
        repeat (PERIOD) begin
            @(negedge clk);
            if (pwm_out[1] === 1'b1) hi++;
        end
        checks++; if (hi != 10) begin errors++; $display("FAIL fade_final_duty: got %0d required 10", hi); end
    endtask

    task automatic test_reverse();
        int n = 0, lows = 0, len = 0, mism = 0;
        send_cmd(2, 100, 1'b1);
        while (m_cur[2] != 20 && n < 400) begin
            @(negedge clk); n++;
            if (busy[2] !== 1'b1) lows++;
        end
        checks++; if (n >= 400) begin errors++; $display("FAIL reverse_reach20: cur=%0d required 20", m_cur[2]); end
        send_cmd(2, 5, 1'b1);
        while (busy[2] === 1'b1 && len < 300) begin
            @(negedge clk); len++;
            if (pwm_out !== exp_pwm() || busy !== exp_busy()) mism++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL reverse_busy_gap: %0d low cycles required 0", lows); end
        checks++; if (len < 56 || len > 68) begin errors++; $display("FAIL reverse_duration: got %0d required 56..68", len); end
        checks++; if (mism != 0) begin errors++; $display("FAIL reverse_model: %0d mismatching cycles required 0", mism); end
    endtask

    task automatic test_random();
        int sent = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            checks++;
            if (pwm_out !== exp_pwm()) begin
                errors++;
                if (errors < 20) $display("FAIL rand_pwm: cycle %0d got %b required %b", cyc, pwm_out, exp_pwm());
            end
            checks++;
            if (busy !== exp_busy() || cmd_ready !== m_ready) begin
                errors++;
                if (errors < 20) $display("FAIL rand_ctrl: cycle %0d busy %b/%b ready %b/%b", cyc, busy, exp_busy(), cmd_ready, m_ready);
            end
            if (cmd_valid && !cmd_ready) begin
                cmd_valid = 1'b0;
            end else if (!cmd_valid && $urandom_range(0, 39) == 0) begin
                cmd_chan  = 2'($urandom_range(0, 3));
                cmd_level = 8'($urandom_range(0, 255));
                cmd_fade  = 1'($urandom_range(0, 1));
                cmd_valid = 1'b1;
                sent++;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (sent < 20) begin errors++; $display("FAIL rand_cmd_count: got %0d required >=20", sent); end
    endtask

    task automatic test_back_to_back();
        int acc[4];
        int cyc = 0, k = 0;
        @(negedge clk);
        cmd_chan = 2'd0; cmd_level = 8'($urandom_range(0, 100)); cmd_fade = 1'b0;
        cmd_valid = 1'b1;
        while (k < 4 && cyc < 40) begin
            if (cmd_ready) begin
                acc[k] = cyc; k++;
                @(negedge clk); cyc++;
                if (k < 3) begin
                    cmd_chan = 2'(k); cmd_level = 8'($urandom_range(0, 100)); cmd_fade = 1'b0;
                end else begin
                    cmd_chan = 2'd3; cmd_level = 8'd200; cmd_fade = 1'b1;
                end
            end else begin
                @(negedge clk); cyc++;
            end
        end
        cmd_valid = 1'b0;
        checks++; if (k != 4) begin errors++; $display("FAIL b2b_count: got %0d accepts required 4", k); end
        for (int i = 1; i < k; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 2) begin
                errors++; $display("FAIL b2b_spacing: accept %0d gap %0d required 2", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        repeat (20) @(negedge clk);
        checks++; if (busy !== 3'b111) begin errors++; $display("FAIL mid_ramping: busy %b required 111", busy); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pwm_out !== 3'b000 || busy !== 3'b000 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset: pwm %b busy %b ready %b required 000 000 1", pwm_out, busy, cmd_ready);
        end
        @(negedge clk) rst = 1'b0;
        send_cmd(3, 255, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL pend_reset_ready: got %b required 1", cmd_ready); end
        @(negedge clk) rst = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (pwm_out !== 3'b000 || busy !== 3'b000) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pend_discard: %0d active cycles required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_extremes();
        test_fade();
        test_reverse();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
